prbs_15_checker: RTL and testbench
==================================

# prbs_15_checker

- Receive-side checker fed by the PRBS-15 byte generator's `prbs_out` stream.
- Verifies the 32-bit preamble pattern repeated `n` times, then self-synchronises to the following PRBS-15 data (x^15 + x^14 + 1).
- Declares lock once synchronised and counts bit errors while locked.
- Sits directly downstream of the generator in loopback/link test benches and on-chip BIST.

## Interface
Parameters:
- `ERR_W`, 16: width of the saturating bit-error counter.
- `LOCK_CNT`, 4: consecutive clean bytes to gain lock, and consecutive errored bytes to lose it.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `clear` in 1: synchronous restart to IDLE, zeroes counters and flags.
- `data_in` in 8: received byte; first bit in time is the MSB.
- `data_valid` in 1: `data_in` is sampled only when this is high.
- `pattern` in 32: expected preamble; bytes are sent MSB byte first.
- `n` in 4: number of preamble repetitions.
- `pattern_done` out 1: preamble phase finished.
- `pattern_err` out 1: sticky; a preamble byte mismatched.
- `prbs_locked` out 1: high while in the LOCKED state.
- `err_flag` out 1: one-cycle pulse; the last locked byte had ≥1 bit error.
- `err_count` out ERR_W: accumulated bit errors while locked; saturates.

## Operation
- All outputs are registered. Reset value of every output is 0, and the state on reset is IDLE.
- `rst` has priority over `clear`. `clear` has priority over `data_valid`.
- Cycles with `data_valid`=0 hold all state and counters.
- States:
  - IDLE: the first valid byte latches `pattern`/`n` into shadow registers.
    - If shadow n≠0, that byte is processed as preamble byte 0 and the state goes to PATTERN.
    - If n=0, the state goes straight to SEED, and that byte counts as seed byte 0.
  - PATTERN: byte index i runs 0..4n-1 and is compared with `pattern[31-8*(i%4) -: 8]`.
    - A mismatch sets `pattern_err` and does not abort the phase.
    - After byte 4n-1: `pattern_done`=1 (sticky until rst/clear) and the state goes to SEED.
  - SEED: two valid bytes are shifted into the 16-bit history. The LFSR state is the last 15 received bits. Then the state goes to SYNC.
  - SYNC: for each byte, predict 8 bits by stepping b[k]=b[k-14]^b[k-15] eight times, and compare with `data_in`.
    - The state is reloaded from the received bits (self-synchronising).
    - A clean byte increments the clean counter; an errored byte clears it.
    - Clean counter = LOCK_CNT → LOCKED.
  - LOCKED: the state advances from the predicted bits, not the received ones, so errors do not propagate.
    - popcount(received XOR predicted), 0..8, is added to `err_count`, which saturates at 2^ERR_W-1.
    - `err_flag` pulses when popcount>0.
    - LOCK_CNT consecutive errored bytes → SYNC, with `prbs_locked`←0 and the clean counter zeroed. `err_count` is retained.
- `err_count` only counts in LOCKED. Errors seen in SYNC are never counted.
- `pattern`/`n` changes after IDLE are ignored until rst/clear.

## Timing
- Latency is one cycle: a byte sampled at edge k updates flags and counters visible after edge k.
  - `pattern_done` rises the cycle after preamble byte 4n-1 is sampled.
  - `prbs_locked` rises the cycle after the LOCK_CNT-th clean SYNC byte.
  - `err_flag`/`err_count` reflect a locked byte one cycle after it is sampled.
- Best case after the preamble: 2 seed bytes + LOCK_CNT bytes until lock, i.e. 6 valid bytes at defaults.
- `rst` asserted mid-stream clears all outputs immediately, without waiting for a clock edge.
- `clear` takes effect at the next edge, and any byte sampled that cycle is discarded.

## Configuration
- `PRBS_CHK_BYTE_CNT_EN`:
  - Defined: adds output port `byte_count` [31:0], counting valid bytes checked in LOCKED. It wraps at 2^32, resets to 0 on rst/clear, and has the same one-cycle latency as `err_count`.
  - Undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- pattern=0xA5A6A7A8, n=4, stream A5 A6 A7 A8 ×4 then clean PRBS-15 → `pattern_done`=1 after byte 16, `pattern_err`=0, `prbs_locked`=1 after byte 22, `err_count`=0 thereafter.
- pattern=0x5A5A5A5A, n=8, byte 5 corrupted to 0x00 → `pattern_err`=1, `pattern_done` still after byte 32, then lock as normal.
- Locked, flip 3 bits in one byte → single `err_flag` pulse, `err_count`=3. Next byte clean → `err_count` stays 3 and the LFSR state is not corrupted.
- Locked, 4 consecutive bytes forced to 0xFF → `prbs_locked` falls after the 4th byte. Clean data then re-locks after 4 clean bytes, and `err_count` is retained.
- n=0 → no preamble check; `prbs_locked` after 6 valid PRBS bytes. `data_valid` toggling 1/0 → lock after the same number of valid bytes.
- Assert `rst` mid-LOCKED → all outputs 0 immediately. Assert `clear` and `data_valid` together → IDLE, counters 0, byte discarded. With `err_count` preset near max and ERR_W=4 → saturates at 15.

Source files
------------

// File: rtl/prbs_15_checker.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : prbs_15_checker
// Function : PRBS-15 (x^15 + x^14 + 1) receive checker. Verifies an N-times
//            repeated 32-bit preamble, self-synchronises, locks, and counts
//            bit errors while locked. Define PRBS_CHK_BYTE_CNT_EN to add the
//            byte_count output.
// Revision : 1.0 - initial release
// ============================================================================
module prbs_15_checker #(
    parameter int ERR_W    = 16,
    parameter int LOCK_CNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic [31:0]      pattern,
    input  logic [3:0]       n,
    output logic             pattern_done,
    output logic             pattern_err,
    output logic             prbs_locked,
    output logic             err_flag,
`ifdef PRBS_CHK_BYTE_CNT_EN
    output logic [31:0]      byte_count,
`endif
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(LOCK_CNT - 1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_PATTERN = 3'd1;
    localparam logic [2:0] c_ST_SEED    = 3'd2;
    localparam logic [2:0] c_ST_SYNC    = 3'd3;
    localparam logic [2:0] c_ST_LOCKED  = 3'd4;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [31:0]      r_pat;
    logic [3:0]       r_n;
    logic [5:0]       r_idx;
    logic             r_seed;
    logic [14:0]      r_lfsr;
    logic [CNT_W-1:0] r_clean;
    logic [CNT_W-1:0] r_bad;
    logic             r_pattern_done;
    logic             r_pattern_err;
    logic             r_locked;
    logic             r_err_flag;
    logic [ERR_W-1:0] r_err_count;
`ifdef PRBS_CHK_BYTE_CNT_EN
    logic [31:0]      r_byte_count;
`endif

    logic [7:0]       w_pred;
    logic [14:0]      w_lfsr_pred;
    logic [14:0]      w_lfsr_rx;
    logic [7:0]       w_diff;
    logic [3:0]       w_pop;
    logic [7:0]       w_pat_byte;
    logic             w_pat_last;
    logic             w_clean_hit;
    logic             w_bad_hit;
    logic [ERR_W+3:0] w_err_sum;
    logic [ERR_W-1:0] w_err_sat;
    logic             w_locked_nxt;
    logic             w_err_flag_nxt;
    logic             w_perr_set;
    logic             w_done_set;

    // r_lfsr[0] is the most recent bit, r_lfsr[14] the oldest.
    always_comb begin : p_predict
        logic [14:0] w_s;
        w_s    = r_lfsr;
        w_pred = '0;
        for (int k = 7; k >= 0; k--) begin
            w_pred[k] = w_s[13] ^ w_s[14];
            w_s       = {w_s[13:0], w_s[13] ^ w_s[14]};
        end
        w_lfsr_pred = w_s;
    end

    assign w_lfsr_rx = {r_lfsr[6:0], data_in};
    assign w_diff    = data_in ^ w_pred;

    always_comb begin : p_popcount
        w_pop = '0;
        for (int k = 0; k < 8; k++) begin
            w_pop = w_pop + {3'b000, w_diff[k]};
        end
    end

    assign w_err_sum = {4'b0000, r_err_count} + {{ERR_W{1'b0}}, w_pop};
    assign w_err_sat = (|w_err_sum[ERR_W+3:ERR_W]) ? {ERR_W{1'b1}} : w_err_sum[ERR_W-1:0];

    always_comb begin : p_pat_byte
        case (r_idx[1:0])
            2'd0:    w_pat_byte = r_pat[31:24];
            2'd1:    w_pat_byte = r_pat[23:16];
            2'd2:    w_pat_byte = r_pat[15:8];
            default: w_pat_byte = r_pat[7:0];
        endcase
    end

    // Last preamble byte index is 4n-1.
    assign w_pat_last  = (r_idx == {r_n - 4'd1, 2'b11});
    assign w_clean_hit = (w_pop == 4'd0) && (r_clean == c_LAST);
    assign w_bad_hit   = (w_pop != 4'd0) && (r_bad == c_LAST);

    always_ff @(posedge clk or posedge rst) begin : p_state_reg
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = c_ST_IDLE;
        end else if (data_valid) begin
            case (r_state)
                c_ST_IDLE:    w_state_nxt = (n != 4'd0) ? c_ST_PATTERN : c_ST_SEED;
                c_ST_PATTERN: if (w_pat_last) w_state_nxt = c_ST_SEED;
                c_ST_SEED:    if (r_seed) w_state_nxt = c_ST_SYNC;
                c_ST_SYNC:    if (w_clean_hit) w_state_nxt = c_ST_LOCKED;
                c_ST_LOCKED:  if (w_bad_hit) w_state_nxt = c_ST_SYNC;
                default:      w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin : p_fsm_out
        w_locked_nxt   = (w_state_nxt == c_ST_LOCKED);
        w_err_flag_nxt = 1'b0;
        w_perr_set     = 1'b0;
        w_done_set     = 1'b0;
        if (data_valid && !clear) begin
            case (r_state)
                c_ST_IDLE: begin
                    w_perr_set = (n != 4'd0) && (data_in != pattern[31:24]);
                end
                c_ST_PATTERN: begin
                    w_perr_set = (data_in != w_pat_byte);
                    w_done_set = w_pat_last;
                end
                c_ST_LOCKED: begin
                    w_err_flag_nxt = (w_pop != 4'd0);
                end
                default: begin
                    w_err_flag_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_flags
        if (rst) begin
            r_pattern_done <= 1'b0;
            r_pattern_err  <= 1'b0;
            r_locked       <= 1'b0;
            r_err_flag     <= 1'b0;
        end else if (clear) begin
            r_pattern_done <= 1'b0;
            r_pattern_err  <= 1'b0;
            r_locked       <= 1'b0;
            r_err_flag     <= 1'b0;
        end else begin
            r_pattern_done <= r_pattern_done | w_done_set;
            r_pattern_err  <= r_pattern_err | w_perr_set;
            r_locked       <= w_locked_nxt;
            r_err_flag     <= w_err_flag_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : p_datapath
        if (rst) begin
            r_pat        <= '0;
            r_n          <= '0;
            r_idx        <= '0;
            r_seed       <= 1'b0;
            r_lfsr       <= '0;
            r_clean      <= '0;
            r_bad        <= '0;
            r_err_count  <= '0;
`ifdef PRBS_CHK_BYTE_CNT_EN
            r_byte_count <= '0;
`endif
        end else if (clear) begin
            r_pat        <= '0;
            r_n          <= '0;
            r_idx        <= '0;
            r_seed       <= 1'b0;
            r_lfsr       <= '0;
            r_clean      <= '0;
            r_bad        <= '0;
            r_err_count  <= '0;
`ifdef PRBS_CHK_BYTE_CNT_EN
            r_byte_count <= '0;
`endif
        end else if (data_valid) begin
            case (r_state)
                c_ST_IDLE: begin
                    r_pat <= pattern;
                    r_n   <= n;
                    if (n != 4'd0) begin
                        r_idx <= 6'd1;
                    end else begin
                        r_lfsr <= w_lfsr_rx;
                        r_seed <= 1'b1;
                    end
                end
                c_ST_PATTERN: begin
                    r_idx <= r_idx + 6'd1;
                    if (w_pat_last) begin
                        r_seed <= 1'b0;
                    end
                end
                c_ST_SEED: begin
                    r_lfsr <= w_lfsr_rx;
                    r_seed <= 1'b1;
                    if (r_seed) begin
                        r_clean <= '0;
                        r_bad   <= '0;
                    end
                end
                c_ST_SYNC: begin
                    // Self-synchronise: the next prediction starts from received bits.
                    r_lfsr <= w_lfsr_rx;
                    if (w_pop != 4'd0) begin
                        r_clean <= '0;
                    end else if (w_clean_hit) begin
                        r_clean <= '0;
                        r_bad   <= '0;
                    end else begin
                        r_clean <= r_clean + 1'b1;
                    end
                end
                c_ST_LOCKED: begin
                    // Free-run on predicted bits so line errors do not propagate.
                    r_lfsr      <= w_lfsr_pred;
                    r_err_count <= w_err_sat;
`ifdef PRBS_CHK_BYTE_CNT_EN
                    r_byte_count <= r_byte_count + 32'd1;
`endif
                    if (w_pop == 4'd0) begin
                        r_bad <= '0;
                    end else if (w_bad_hit) begin
                        r_bad   <= '0;
                        r_clean <= '0;
                    end else begin
                        r_bad <= r_bad + 1'b1;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign pattern_done = r_pattern_done;
    assign pattern_err  = r_pattern_err;
    assign prbs_locked  = r_locked;
    assign err_flag     = r_err_flag;
    assign err_count    = r_err_count;
`ifdef PRBS_CHK_BYTE_CNT_EN
    assign byte_count   = r_byte_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prbs_15_checker.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_prbs_15_checker
// Function : Directed scoreboard bench for prbs_15_checker (ERR_W 16 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_15_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [7:0]  din;
    logic        dv;
    logic [31:0] pat;
    logic [3:0]  nn;

    logic        done_o, perr_o, lock_o, flag_o;
    logic [15:0] cnt_o;
    logic        done_s, perr_s, lock_s, flag_s;
    logic [3:0]  cnt_s;
`ifdef PRBS_CHK_BYTE_CNT_EN
    logic [31:0] bc_o, bc_s;
`endif

    always #5 clk = ~clk;

    prbs_15_checker #(.ERR_W(16), .LOCK_CNT(4)) u_dut (
        .clk(clk), .rst(rst), .clear(clear), .data_in(din), .data_valid(dv),
        .pattern(pat), .n(nn), .pattern_done(done_o), .pattern_err(perr_o),
        .prbs_locked(lock_o), .err_flag(flag_o),
`ifdef PRBS_CHK_BYTE_CNT_EN
        .byte_count(bc_o),
`endif
        .err_count(cnt_o)
    );

    prbs_15_checker #(.ERR_W(4), .LOCK_CNT(4)) u_dut_sat (
        .clk(clk), .rst(rst), .clear(clear), .data_in(din), .data_valid(dv),
        .pattern(pat), .n(nn), .pattern_done(done_s), .pattern_err(perr_s),
        .prbs_locked(lock_s), .err_flag(flag_s),
`ifdef PRBS_CHK_BYTE_CNT_EN
        .byte_count(bc_s),
`endif
        .err_count(cnt_s)
    );

    typedef struct packed {
        logic        done;
        logic        perr;
        logic        lock;
        logic        flag;
        logic [15:0] cnt;
        logic [3:0]  cnt_s;
        logic [31:0] bc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [14:0] g;
    logic        e_done, e_perr, e_lock, e_flag, p_lock;
    logic [15:0] e_cnt;
    logic [31:0] e_bc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        e_done = 1'b0; e_perr = 1'b0; e_lock = 1'b0; e_flag = 1'b0;
        e_cnt  = '0;   e_bc   = '0;   p_lock = 1'b0;
    endtask

    // PRBS-15 source: b[k] = b[k-14] ^ b[k-15], first bit in time is the MSB.
    task automatic gen(output logic [7:0] b);
        for (int k = 7; k >= 0; k--) begin
            b[k] = g[13] ^ g[14];
            g    = {g[13:0], b[k]};
        end
    endtask

    task automatic send(input logic [7:0] d, input logic v);
        exp_t e, o;
        @(negedge clk);
        din = d;
        dv  = v;
        if (v && p_lock) e_bc = e_bc + 32'd1;
        e.done  = e_done;
        e.perr  = e_perr;
        e.lock  = e_lock;
        e.flag  = e_flag;
        e.cnt   = e_cnt;
        e.cnt_s = (e_cnt > 16'd15) ? 4'd15 : e_cnt[3:0];
        e.bc    = e_bc;
        q.push_back(e);
        p_lock = e_lock;
        @(posedge clk);
        #1;
        dv = 1'b0;
        o  = q.pop_front();
        chk("pattern_done", {31'd0, done_o}, {31'd0, o.done});
        chk("pattern_err",  {31'd0, perr_o}, {31'd0, o.perr});
        chk("prbs_locked",  {31'd0, lock_o}, {31'd0, o.lock});
        chk("err_flag",     {31'd0, flag_o}, {31'd0, o.flag});
        chk("err_count",    {16'd0, cnt_o},  {16'd0, o.cnt});
        chk("err_count_w4", {28'd0, cnt_s},  {28'd0, o.cnt_s});
`ifdef PRBS_CHK_BYTE_CNT_EN
        chk("byte_count",   bc_o, o.bc);
`endif
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_perr"}, {31'd0, perr_o}, 32'd0);
        chk({tag, "_lock"}, {31'd0, lock_o}, 32'd0);
        chk({tag, "_flag"}, {31'd0, flag_o}, 32'd0);
        chk({tag, "_cnt"},  {16'd0, cnt_o},  32'd0);
        chk({tag, "_cnt4"}, {28'd0, cnt_s},  32'd0);
    endtask

    initial begin
        logic [7:0]  b, f;
        logic [31:0] p1, p2;
        rst = 1'b1; clear = 1'b0; dv = 1'b0; din = '0; pat = '0; nn = '0;
        g   = 15'h1ACE;
        reset_model();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Preamble A5A6A7A8 x4; later pattern/n changes must be ignored.
        p1 = 32'hA5A6A7A8;
        pat = p1; nn = 4'd4;
        for (int i = 0; i < 16; i++) begin
            e_done = (i == 15);
            send(p1[31-8*(i%4) -: 8], 1'b1);
            if (i == 0) begin pat = 32'h0; nn = 4'd1; end
        end
        for (int i = 0; i < 6; i++) begin
            gen(b); e_lock = (i == 5); send(b, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            gen(b); send(b, 1'b1);
            if (i == 2) send(8'h00, 1'b0);
        end

        // Three flipped bits in one locked byte.
        gen(b); e_flag = 1'b1; e_cnt = e_cnt + 16'd3; send(b ^ 8'h43, 1'b1);
        e_flag = 1'b0;
        gen(b); send(b, 1'b1);
        gen(b); send(b, 1'b1);

        // Four consecutive errored bytes drop lock; count is retained.
        for (int i = 0; i < 4; i++) begin
            gen(b);
            f = (b == 8'hFF) ? 8'h00 : 8'hFF;
            e_cnt  = e_cnt + 16'($countones(b ^ f));
            e_flag = 1'b1;
            e_lock = (i != 3);
            send(f, 1'b1);
        end
        e_flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gen(b); e_lock = (i == 3); send(b, 1'b1);
        end

        // Push the 4-bit instance into saturation without losing lock.
        for (int i = 0; i < 5; i++) begin
            gen(b);
            if (i == 2) begin
                e_flag = 1'b0; send(b, 1'b1);
            end else begin
                e_flag = 1'b1; e_cnt = e_cnt + 16'd8; send(~b, 1'b1);
            end
        end
        e_flag = 1'b0;
        gen(b); send(b, 1'b1);

        // Asynchronous reset mid-LOCKED.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        reset_model();

        // n=8 preamble with one corrupted byte.
        p2 = 32'h5A5A5A5A;
        pat = p2; nn = 4'd8;
        for (int i = 0; i < 32; i++) begin
            b = p2[31-8*(i%4) -: 8];
            if (i == 5) begin b = 8'h00; e_perr = 1'b1; end
            e_done = (i == 31);
            send(b, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            gen(b); e_lock = (i == 5); send(b, 1'b1);
        end
        gen(b); send(b, 1'b1);

        // clear together with data_valid: back to IDLE, byte discarded.
        @(negedge clk);
        clear = 1'b1; dv = 1'b1; din = 8'h3C;
        @(posedge clk);
        #1;
        clear = 1'b0; dv = 1'b0;
        chk_zero("clear");
        reset_model();

        // n=0: no preamble, data_valid toggling.
        nn = 4'd0;
        for (int i = 0; i < 6; i++) begin
            gen(b); e_lock = (i == 5); send(b, 1'b1);
            if (i < 5) send(8'h00, 1'b0);
        end
        gen(b); send(b, 1'b1);
        gen(b); send(b, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
